// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU with shift-add multiplier and valid/ready handshakes
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             Ovf_o,
  output logic             Err_o
);

  // Multiplier retires MUL_BPC bits per step; STEPS steps complete one product.
  localparam int STEPS = WIDTH / MUL_BPC;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;        // multiplicand, shifted left each step
  logic [WIDTH-1:0] b_q, b_d;        // multiplier, shifted right each step
  logic [WIDTH-1:0] acc_q, acc_d;    // running partial product
  logic [CNT_W-1:0] cnt_q, cnt_d;    // steps completed
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_err;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] diff_w;
  logic             slt_w;
  logic [WIDTH-1:0] step_sum;

  logic accept;
  logic is_mul;
  logic last_step;

  assign accept    = valid_i && (state_q == S_IDLE);
  assign is_mul    = (ALUCtrl_i == OP_MUL);
  assign last_step = (cnt_q == LAST_STEP);

  // State register; reset forces IDLE and aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: MUL takes the iterative path, everything else goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = is_mul ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      S_IDLE:  ready_o = 1'b1;
      S_DONE:  valid_o = 1'b1;
      default: begin
        ready_o = 1'b0;
        valid_o = 1'b0;
      end
    endcase
  end

  // Single-cycle ALU evaluated straight from the request operands.
  always_comb begin
    sum_w   = data1_i + data2_i;
    diff_w  = data1_i - data2_i;
    slt_w   = $signed(data1_i) < $signed(data2_i);
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (ALUCtrl_i)
      OP_AND: alu_res = data1_i & data2_i;
      OP_OR:  alu_res = data1_i | data2_i;
      OP_XOR: alu_res = data1_i ^ data2_i;
      OP_ADD: begin
        alu_res = sum_w;
        // Like-signed operands producing an opposite-signed sum overflowed.
        alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != data1_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w;
        // Unlike-signed operands whose difference takes the subtrahend's sign overflowed.
        alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != data1_i[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_w};
      OP_RSV: alu_err = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand for each set multiplier bit in this slice.
  always_comb begin
    step_sum = acc_q;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (b_q[j]) begin
        step_sum = step_sum + (a_q << j);
      end
    end
  end

  // Datapath next-state: capture on accept, iterate in MUL, hold the result in DONE.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            a_d   = data1_i;
            b_d   = data2_i;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            data_d = alu_res;
            ovf_d  = alu_ovf;
            err_d  = alu_err;
          end
        end
      end
      S_MUL: begin
        acc_d = step_sum;
        a_d   = a_q << MUL_BPC;
        b_d   = b_q >> MUL_BPC;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          data_d = step_sum;
          ovf_d  = 1'b0;
          err_d  = 1'b0;
        end
      end
      default: begin
        data_d = data_q;
      end
    endcase
  end

  // Datapath registers; reset clears the result so Zero_o reads 1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  assign data_o = data_q;
  assign Zero_o = (data_q == '0);
  assign Ovf_o  = ovf_q;
  assign Err_o  = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed scoreboard bench for alu_multicycle
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  op_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        zero_o;
  logic        ovf_o;
  logic        err_o;

  logic        valid4;
  logic        ready4;
  logic        ready4_o;
  logic        valid4_o;
  logic [31:0] data4_o;
  logic        zero4_o;
  logic        ovf4_o;
  logic        err4_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .MUL_BPC(1)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data1_i(data1), .data2_i(data2), .ALUCtrl_i(op_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .Zero_o(zero_o), .Ovf_o(ovf_o), .Err_o(err_o)
  );

  alu_multicycle #(.WIDTH(32), .MUL_BPC(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid4), .ready_o(ready4_o),
    .data1_i(data1), .data2_i(data2), .ALUCtrl_i(op_i), .valid_o(valid4_o),
    .ready_i(ready4), .data_o(data4_o), .Zero_o(zero4_o), .Ovf_o(ovf4_o), .Err_o(err4_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model in 64-bit signed arithmetic, independent of the RTL structure.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb_v;
    longint      r;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.data = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1;
    case (op)
      3'b000: e.data = a & b;
      3'b001: e.data = a | b;
      3'b100: e.data = a ^ b;
      3'b010: begin
        r = sa + sb_v;
        e.data = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b110: begin
        r = sa - sb_v;
        e.data = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b011: begin
        p = {32'd0, a} * {32'd0, b};
        e.data = p[31:0];
        e.lat = 33;
      end
      3'b111: e.data = (sa < sb_v) ? 32'd1 : 32'd0;
      default: begin
        e.data = '0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.data == 32'd0);
    return e;
  endfunction

  // Issue one request, wait for its result, check it, optionally stall, then hand it off.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    exp_t e;
    int   n;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    chk({tag, " ready_before"}, ready_o, 1);
    valid_i = 1'b1; op_i = o; data1 = a; data2 = b;
    @(posedge clk); #1;
    valid_i = 1'b0; data1 = $urandom; data2 = $urandom; op_i = 3'($urandom);
    n = 0;
    while (valid_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, n + 1, e.lat);
    chk({tag, " data"}, data_o, e.data);
    chk({tag, " zero"}, zero_o, e.zero);
    chk({tag, " ovf"}, ovf_o, e.ovf);
    chk({tag, " err"}, err_o, e.err);
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'b1; op_i = 3'b010; data1 = $urandom; data2 = $urandom;
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, valid_o, 1);
      chk({tag, " hold_ready"}, ready_o, 0);
      chk({tag, " hold_data"}, data_o, e.data);
      chk({tag, " hold_flags"}, {zero_o, ovf_o, err_o}, {e.zero, e.ovf, e.err});
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({tag, " post_valid"}, valid_o, 0);
    chk({tag, " post_ready"}, ready_o, 1);
  endtask

  initial begin
    int   n;
    int   vseen;
    exp_t e;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; valid4 = 1'b0; ready4 = 1'b1;
    data1 = '0; data2 = '0; op_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", ready_o, 1);
    chk("reset valid", valid_o, 0);
    chk("reset data", data_o, 0);
    chk("reset flags", {zero_o, ovf_o, err_o}, 3'b100);
    rst_n = 1'b1;

    // First accept lands on the first rising edge after release.
    do_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op("sub_zero", 3'b110, 32'd5, 32'd5, 0);
    do_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("slt_pos", 3'b111, 32'd1, 32'hFFFF_FFFF, 0);
    do_op("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 0);
    do_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    do_op("xor", 3'b100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    do_op("mul_a", 3'b011, 32'h0001_0001, 32'h0001_0001, 0);
    do_op("mul_b", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    do_op("or_bp", 3'b001, 32'h1200_0034, 32'h0056_7800, 5);
    do_op("after_bp", 3'b010, 32'd100, 32'hFFFF_FFFF, 0);
    do_op("reserved", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op("add_1_1", 3'b010, 32'd1, 32'd1, 0);

    // ready_i while nothing is pending must not disturb the idle block.
    @(negedge clk);
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ready_i = 1'b0;
    chk("stray_ready valid", valid_o, 0);
    chk("stray_ready ready", ready_o, 1);

    // Four bits per cycle: same product, nine-cycle latency.
    sb.push_back(model(3'b011, 32'h0001_0001, 32'h0001_0001));
    sb[0].lat = 9;
    @(negedge clk);
    valid4 = 1'b1; op_i = 3'b011; data1 = 32'h0001_0001; data2 = 32'h0001_0001;
    @(posedge clk); #1;
    valid4 = 1'b0; data1 = $urandom; data2 = $urandom;
    n = 0;
    while (valid4_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk("mul_bpc4 latency", n + 1, e.lat);
    chk("mul_bpc4 data", data4_o, e.data);
    chk("mul_bpc4 flags", {zero4_o, ovf4_o, err4_o}, {e.zero, e.ovf, e.err});

    // Reset ten cycles into a multiply: outputs drop immediately, no result later.
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'b011; data1 = 32'h0000_0003; data2 = 32'h0000_0007;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_mul_rst ready", ready_o, 1);
    chk("mid_mul_rst valid", valid_o, 0);
    chk("mid_mul_rst data", data_o, 0);
    chk("mid_mul_rst flags", {zero_o, ovf_o, err_o}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    vseen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o === 1'b1) vseen++;
    end
    chk("mid_mul_rst no_valid", vseen, 0);
    do_op("after_rst", 3'b010, 32'd40, 32'd2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter MUL_BPC, default 1, meaning the multiplier bits retired per cycle; legal values are 1, 2 and 4, and WIDTH % MUL_BPC == 0.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 valid_i  input  1  operation request valid.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 data1_i  input  WIDTH  operand A.
REQ-008 data2_i  input  WIDTH  operand B.
REQ-009 ALUCtrl_i  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL, 100 XOR, 111 SLT (signed), 101 reserved.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 data_o  output  WIDTH  result.
REQ-013 Zero_o  output  1  data_o equals zero.
REQ-014 Ovf_o  output  1  signed overflow; meaningful for ADD/SUB only.
REQ-015 Err_o  output  1  reserved opcode executed.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-017 ready_o SHALL be 1 only in IDLE.
REQ-018 A request is accepted on a clock edge with valid_i=1 and ready_o=1; operands and opcode are captured at that edge.
REQ-019 Non-MUL opcodes: IDLE->DONE on accept; result registered, so valid_o rises exactly 1 cycle after accept.
REQ-020 MUL: IDLE->MUL on accept; shift-add over MUL_BPC multiplier bits per cycle; MUL->DONE after WIDTH/MUL_BPC cycles; valid_o rises WIDTH/MUL_BPC+1 cycles after accept.
REQ-021 MUL result SHALL be the low WIDTH bits of the unsigned product; upper bits are discarded.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; Ovf_o = 1 when the signed result sign differs from the mathematically correct sign; Ovf_o = 0 for all other opcodes.
REQ-023 SLT SHALL return 1 (zero-extended) if data1_i < data2_i as two's-complement, else 0.
REQ-024 Reserved opcode 101 SHALL take the 1-cycle path with data_o = 0, Zero_o = 1, Err_o = 1; Err_o = 0 otherwise.
REQ-025 Zero_o SHALL be derived from the registered data_o being presented, never from a previous result.
REQ-026 In DONE, valid_o = 1 and data_o/Zero_o/Ovf_o/Err_o SHALL hold stable until valid_o and ready_i are both 1 on a clock edge; DONE->IDLE then.
REQ-027 valid_i asserted while ready_o = 0 SHALL be ignored; no queueing; input changes during MUL SHALL not affect the result.
REQ-028 ready_i asserted while valid_o = 0 SHALL have no effect.
REQ-029 Back-to-back: a new request SHALL be acceptable in the cycle immediately following a result handshake; max throughput is one op per 2 cycles.

Reset
REQ-030 While rst_i = 0, the FSM SHALL be in IDLE, with ready_o = 1, valid_o = 0, data_o = 0, Zero_o = 1, Ovf_o = 0, Err_o = 0, and multiply counter/accumulator = 0.
REQ-031 Reset asserted mid-MUL or in DONE SHALL abort the operation immediately and discard the result; no valid_o pulse after release.
REQ-032 The first accept SHALL be possible on the first rising edge with rst_i = 1.

Verification
REQ-033 WIDTH=32: ADD 0x7FFFFFFF + 0x00000001 -> valid_o 1 cycle after accept, data_o = 0x80000000, Ovf_o = 1, Zero_o = 0.
REQ-034 SUB 5 - 5 -> data_o = 0, Zero_o = 1, Ovf_o = 0; SLT 0xFFFFFFFF vs 1 -> data_o = 1.
REQ-035 MUL 0x00010001 * 0x00010001, MUL_BPC=1 -> valid_o exactly 33 cycles after accept, data_o = 0x00020001; MUL_BPC=4 -> 9 cycles, same result.
REQ-036 Backpressure: ready_i = 0 for 5 cycles in DONE -> outputs stable, ready_o = 0, extra valid_i ignored; ready_i = 1 -> IDLE next cycle, next op accepted.
REQ-037 Reset: rst_i pulled low at cycle 10 of a MUL -> outputs at reset values asynchronously; no valid_o after release.
REQ-038 Opcode 101 -> data_o = 0, Zero_o = 1, Err_o = 1; the following ADD 1+1 -> Err_o = 0, data_o = 2.
